pipeline_ctrl: RTL and testbench

Hazard and sequencing controller for the five-stage core. It drives the level hold and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC hold/redirect. It also resolves load-use hazards, taken-branch squashes with an optional fetch-refill window, and data-memory wait states. Two performance counters record stalled and flushed cycles.

---
 rtl/pipeline_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Hazard and sequencing controller for the five-stage core. Drives the level
// hold/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline
// registers plus the PC hold/redirect. Resolves load-use hazards (one bubble),
// taken-branch squashes with an optional fetch-refill window, and data-memory
// wait states. Two wrapping performance counters track stalled and flushed
// cycles.
//
// Parameters
//   REFILL_CYCLES  extra cycles IF/ID stays flushed after a redirect (0 = none)
//   CNT_W          width of the performance counters
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_rs1, id_rs2             source registers of the instruction in ID
//   id_use_rs1, id_use_rs2     the ID instruction actually reads rs1 / rs2
//   ex_is_load, ex_rd          EX instruction is a load / its destination
//   ex_branch_taken            EX resolved a taken branch or jump
//   mem_req, mem_ack           data-memory access in MEM / completion strobe
//   *_hold                     register keeps its value at the next edge
//   *_flush                    register loads a NOP at the next edge
//   pc_redirect                PC loads the branch target at the next edge
//   stall_count, flush_count   performance counters
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int REFILL_CYCLES = 0,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_hold,
  output logic             exmem_hold,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             pc_redirect,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int RW = (REFILL_CYCLES > 0) ? $clog2(REFILL_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REFILL   = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t          state, state_nxt;
  state_t          ret, ret_nxt;
  state_t          eff;
  logic [RW-1:0]   rcnt, rcnt_nxt;
  logic            mstall;
  logic            load_use;

  assign mstall = mem_req & ~mem_ack;

  // In the ack cycle of MEM_WAIT the controller behaves exactly as the state
  // it interrupted, so every rule below is evaluated against this view.
  assign eff = (state == MEM_WAIT) ? ret : state;

  // x0 is hard-wired zero, so a load targeting it can never feed a consumer.
  assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  // NOTE: every signal driven here gets a default first; a path that skipped
  // an assignment would otherwise infer a latch.
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    idex_hold   = 1'b0;
    exmem_hold  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    pc_redirect = 1'b0;
    state_nxt   = state;
    ret_nxt     = ret;
    rcnt_nxt    = rcnt;

    if (!rst_n) begin
      // Keep NOPs flowing into every stage while the core is held in reset.
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (mstall) begin
      // Freeze everything up to MEM; WB receives bubbles until the ack.
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_hold   = 1'b1;
      exmem_hold  = 1'b1;
      memwb_flush = 1'b1;
      state_nxt   = MEM_WAIT;
      if (state != MEM_WAIT) ret_nxt = state;
    end else begin
      ret_nxt = RUN;
      if (ex_branch_taken) begin
        pc_redirect = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        if (REFILL_CYCLES > 0) begin
          state_nxt = REFILL;
          rcnt_nxt  = RW'(REFILL_CYCLES);
        end else begin
          state_nxt = RUN;
        end
      end else if (eff == REFILL) begin
        // ID holds a squashed fetch, so no load-use check here.
        ifid_flush = 1'b1;
        rcnt_nxt   = rcnt - RW'(1);
        state_nxt  = (rcnt == RW'(1)) ? RUN : REFILL;
      end else begin
        state_nxt = RUN;
        if (load_use) begin
          pc_hold    = 1'b1;
          ifid_hold  = 1'b1;
          idex_flush = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      ret   <= RUN;
      rcnt  <= '0;
    end else begin
      state <= state_nxt;
      ret   <= ret_nxt;
      rcnt  <= rcnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (pc_hold)                 stall_count <= stall_count + CNT_W'(1);
      if (ifid_flush | idex_flush) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
//
// Drives two controllers side by side (REFILL_CYCLES = 2 with 8-bit counters,
// REFILL_CYCLES = 3 with 32-bit counters) from shared inputs. A reference
// model tracks only "refill cycles still owed" and the counter totals; the
// memory stall simply freezes it. Directed scenarios come first, followed by
// a randomized run with occasional asynchronous resets.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_is_load, ex_branch_taken;
  logic       mem_req, mem_ack;

  // Output bundles, order:
  // {pc_hold, ifid_hold, idex_hold, exmem_hold,
  //  ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_redirect}
  logic [8:0]  o_v  [2];
  logic [31:0] sc_v [2];
  logic [31:0] fc_v [2];

  logic [7:0]  sc_a, fc_a;
  logic [31:0] sc_b, fc_b;
  logic        a_ph, a_ih, a_dh, a_eh, a_if, a_df, a_ef, a_mf, a_rd;
  logic        b_ph, b_ih, b_dh, b_eh, b_if, b_df, b_ef, b_mf, b_rd;

  always #5 clk = ~clk;

  pipeline_ctrl #(.REFILL_CYCLES(2), .CNT_W(8)) u_r2 (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_hold(a_ph), .ifid_hold(a_ih), .idex_hold(a_dh), .exmem_hold(a_eh),
    .ifid_flush(a_if), .idex_flush(a_df), .exmem_flush(a_ef), .memwb_flush(a_mf),
    .pc_redirect(a_rd), .stall_count(sc_a), .flush_count(fc_a)
  );

  pipeline_ctrl #(.REFILL_CYCLES(3), .CNT_W(32)) u_r3 (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_hold(b_ph), .ifid_hold(b_ih), .idex_hold(b_dh), .exmem_hold(b_eh),
    .ifid_flush(b_if), .idex_flush(b_df), .exmem_flush(b_ef), .memwb_flush(b_mf),
    .pc_redirect(b_rd), .stall_count(sc_b), .flush_count(fc_b)
  );

  assign o_v[0]  = {a_ph, a_ih, a_dh, a_eh, a_if, a_df, a_ef, a_mf, a_rd};
  assign o_v[1]  = {b_ph, b_ih, b_dh, b_eh, b_if, b_df, b_ef, b_mf, b_rd};
  assign sc_v[0] = {24'd0, sc_a};
  assign fc_v[0] = {24'd0, fc_a};
  assign sc_v[1] = sc_b;
  assign fc_v[1] = fc_b;

  // ---------------------------------------------------------------- model
  localparam int RC [2]  = '{2, 3};
  localparam int CM [2]  = '{32'hFF, 32'hFFFF_FFFF};

  int rl [2];   // refill cycles still owed
  int sc [2];   // stalled cycles seen
  int fc [2];   // flushed cycles seen

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [8:0] model_out(input int left);
    logic hz;
    hz = ex_is_load && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (!rst_n)                  return 9'b0000_1111_0;
    if (mem_req && !mem_ack)     return 9'b1111_0001_0;
    if (ex_branch_taken)         return 9'b0000_1100_1;
    if (left > 0)                return 9'b0000_1000_0;
    if (hz)                      return 9'b1100_0100_0;
    return 9'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      rl[i] = 0; sc[i] = 0; fc[i] = 0;
    end
  endtask

  // One clock: check combinational outputs and counters mid-cycle, then
  // advance the model on the rising edge; returns at posedge + 1.
  task automatic tick(input string tag);
    logic [8:0] e [2];
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      e[i] = model_out(rl[i]);
      check($sformatf("%s/r%0d/out", tag, RC[i]), {23'd0, o_v[i]}, {23'd0, e[i]});
      check($sformatf("%s/r%0d/stall_cnt", tag, RC[i]), sc_v[i], sc[i] & CM[i]);
      check($sformatf("%s/r%0d/flush_cnt", tag, RC[i]), fc_v[i], fc[i] & CM[i]);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        rl[i] = 0; sc[i] = 0; fc[i] = 0;
      end else begin
        if (e[i][8])           sc[i]++;
        if (e[i][4] | e[i][3]) fc[i]++;
        if (!(mem_req && !mem_ack)) begin
          if (ex_branch_taken) rl[i] = RC[i];
          else if (rl[i] > 0)  rl[i]--;
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_is_load = 0; ex_rd = 0; ex_branch_taken = 0; mem_req = 0; mem_ack = 0;
  endtask

  // Asynchronous reset applied between edges; effects must be immediate.
  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s/r%0d/out", tag, RC[i]), {23'd0, o_v[i]}, {23'd0, 9'b0000_1111_0});
      check($sformatf("%s/r%0d/stall_cnt", tag, RC[i]), sc_v[i], 32'd0);
      check($sformatf("%s/r%0d/flush_cnt", tag, RC[i]), fc_v[i], 32'd0);
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) tick("reset");
    rst_n = 1'b1;
    tick("idle");
    check("cnt_start", sc_v[0], 32'd0);

    // Load-use on x5: one bubble.
    ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    tick("load_use");
    check("load_use_stall", sc_v[0], 32'd1);
    // Same shape on x0: nothing happens.
    ex_rd = 0; id_rs1 = 0;
    tick("load_use_x0");
    check("x0_no_stall", sc_v[0], 32'd1);
    // rs2 path.
    ex_rd = 7; id_rs1 = 3; id_rs2 = 7; id_use_rs2 = 1;
    tick("load_use_rs2");
    // Matching register but not actually read.
    id_use_rs2 = 0;
    tick("unused_operand");
    idle_inputs();

    // Branch: redirect cycle plus refill window.
    ex_branch_taken = 1;
    tick("branch");
    ex_branch_taken = 0;
    repeat (3) tick("refill");
    check("branch_flush_r2", fc_v[0], 32'd5);

    // Memory wait of 3 cycles, then ack.
    mem_req = 1;
    repeat (3) tick("mem_wait");
    mem_ack = 1;
    tick("mem_ack");
    idle_inputs();
    check("mem_stall_r2", sc_v[0], 32'd5);
    tick("after_mem");

    // Branch held through a 2-cycle stall: redirect only in the ack cycle.
    ex_branch_taken = 1; mem_req = 1;
    repeat (2) tick("br_in_wait");
    mem_ack = 1;
    tick("br_ack");
    idle_inputs();
    repeat (4) tick("br_ack_refill");

    // Stall in the middle of the REFILL window.
    ex_branch_taken = 1;
    tick("br2");
    ex_branch_taken = 0;
    tick("refill_first");
    mem_req = 1;
    repeat (2) tick("refill_stall");
    mem_ack = 1;
    tick("refill_ack");
    idle_inputs();
    repeat (3) tick("refill_resume");

    // Reset in the middle of MEM_WAIT.
    mem_req = 1;
    repeat (2) tick("pre_reset_wait");
    async_reset("reset_mid_wait");
    idle_inputs();
    tick("in_reset");
    rst_n = 1'b1;
    tick("post_reset");

    // Randomized phase.
    for (int n = 0; n < 2500; n++) begin
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      id_use_rs1      = 1'($urandom_range(0, 1));
      id_use_rs2      = 1'($urandom_range(0, 1));
      ex_is_load      = ($urandom_range(0, 2) != 0);
      ex_rd           = 5'($urandom_range(0, 3));
      ex_branch_taken = ($urandom_range(0, 9) == 0);
      mem_req         = ($urandom_range(0, 3) == 0);
      mem_ack         = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 399) == 0) begin
        async_reset("rand_reset");
        tick("rand_in_reset");
        rst_n = 1'b1;
      end
      tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
